// File: rtl/store_queue_pkg.sv
// -----------------------------------------------------------------------------
// store_queue_pkg
// Shared types and constants for the store queue.
//   sq_entry_t : one queued store {addr, data, wstrb}
//   SIZE_B/H/W : bus transfer size encodings (byte, halfword, word)
// -----------------------------------------------------------------------------
package store_queue_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
    } sq_entry_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/store_size_encode.sv
// -----------------------------------------------------------------------------
// store_size_encode
// Maps a store's byte-lane strobe to a bus transfer size and bus address.
//   i_addr  : entry byte address
//   i_wstrb : entry byte-lane enables
//   o_size  : SIZE_B for one lane, SIZE_H for an aligned lane pair,
//             SIZE_W for anything else (3/4 lanes, swl/swr partials)
//   o_addr  : i_addr, with bits [1:0] cleared for word-sized transfers
// -----------------------------------------------------------------------------
module store_size_encode
    import store_queue_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_wstrb,
    output logic [1:0]  o_size,
    output logic [31:0] o_addr
);

    always_comb begin
        o_size = SIZE_W;
        case (i_wstrb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = SIZE_B;
            4'b0011, 4'b1100:                   o_size = SIZE_H;
            default:                            o_size = SIZE_W;
        endcase
    end

    // Partial-word swl/swr stores go out as word transfers; lanes select bytes.
    assign o_addr = (o_size == SIZE_W) ? {i_addr[31:2], 2'b00} : i_addr;

endmodule

// File: rtl/store_queue.sv
// -----------------------------------------------------------------------------
// store_queue
// In-order store buffer between the MEM stage and a split-transaction data bus.
// Entries are pushed at wr_ptr, issued at iss_ptr (addr_ok handshake) and
// retired at ret_ptr (data_ok completion).
//
// Parameters:
//   DEPTH          : number of entries, power of two, >= 2
// Ports:
//   clk, resetn    : clock, asynchronous active-low reset
//   in_valid/ready : store offer / accept handshake
//   in_addr/data/wstrb : store payload
//   data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb : bus request
//   data_addr_ok   : bus accepted the request
//   data_data_ok   : oldest outstanding write completed
//   empty          : nothing queued or outstanding
//   load_addr      : address of a pending load
//   load_conflict  : the load must wait
//
// Build option: define STORE_QUEUE_LOAD_CHECK_EN to compare load_addr against
// every live entry at word granularity; otherwise any live entry blocks loads.
// -----------------------------------------------------------------------------
module store_queue
    import store_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_wstrb,

    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,

    output logic        empty,

    input  logic [31:0] load_addr,
    output logic        load_conflict
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    sq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_iss_ptr;
    logic [PTR_W-1:0] r_ret_ptr;
    logic [CNT_W-1:0] r_count;    // queued + issued-not-retired
    logic [CNT_W-1:0] r_out_cnt;  // issued-not-retired

    logic      w_push;
    logic      w_issue;
    logic      w_retire;
    sq_entry_t w_iss_entry;

    assign in_ready = (r_count < DEPTH_C);
    assign empty    = (r_count == '0);
    assign data_req = (r_count != r_out_cnt);
    assign data_wr  = 1'b1;

    assign w_push   = in_valid && in_ready;
    assign w_issue  = data_req && data_addr_ok;
    // Completions with nothing outstanding are stray and dropped.
    assign w_retire = data_data_ok && (r_out_cnt != '0);

    assign w_iss_entry = r_mem[r_iss_ptr];
    assign data_wdata  = w_iss_entry.data;
    assign data_wstrb  = w_iss_entry.wstrb;

    store_size_encode u_size_encode (
        .i_addr  (w_iss_entry.addr),
        .i_wstrb (w_iss_entry.wstrb),
        .o_size  (data_size),
        .o_addr  (data_addr)
    );

    // Payload storage carries no reset; liveness comes from the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{addr: in_addr, data: in_data, wstrb: in_wstrb};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr  <= '0;
            r_iss_ptr <= '0;
            r_ret_ptr <= '0;
            r_count   <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_issue) begin
                r_iss_ptr <= r_iss_ptr + PTR_W'(1);
            end
            if (w_retire) begin
                r_ret_ptr <= r_ret_ptr + PTR_W'(1);
            end

            case ({w_push, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            case ({w_issue, w_retire})
                2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
                2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

`ifdef STORE_QUEUE_LOAD_CHECK_EN
    logic [DEPTH-1:0] w_live;
    logic [DEPTH-1:0] w_hit;

    // An entry is live when its distance from ret_ptr is below count.
    always_comb begin
        w_live = '0;
        w_hit  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_live[i] = ({1'b0, PTR_W'(i) - r_ret_ptr} < r_count);
            w_hit[i]  = w_live[i] && (r_mem[i].addr[31:2] == load_addr[31:2]);
        end
    end

    assign load_conflict = |w_hit;
`else
    logic w_unused_load_addr;

    assign w_unused_load_addr = ^load_addr;
    assign load_conflict      = !empty;
`endif

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
    import store_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [3:0]  in_wstrb;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        empty;
    logic [31:0] load_addr;
    logic        load_conflict;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stores waiting to issue, and stores issued but not done.
    sq_entry_t q_pend[$];
    sq_entry_t q_out[$];

    store_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .in_wstrb      (in_wstrb),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_wstrb    (data_wstrb),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .empty         (empty),
        .load_addr     (load_addr),
        .load_conflict (load_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [1:0] exp_size(input logic [3:0] s);
        if ($countones(s) == 1) return 2'd0;
        if (s == 4'b0011 || s == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] exp_addr(input sq_entry_t e);
        if (exp_size(e.wstrb) == 2'd2) return {e.addr[31:2], 2'b00};
        return e.addr;
    endfunction

    function automatic logic exp_conflict(input logic [31:0] la);
`ifdef STORE_QUEUE_LOAD_CHECK_EN
        foreach (q_pend[i]) if (q_pend[i].addr[31:2] == la[31:2]) return 1'b1;
        foreach (q_out[i])  if (q_out[i].addr[31:2] == la[31:2]) return 1'b1;
        return 1'b0;
`else
        return (q_pend.size() + q_out.size()) != 0;
`endif
    endfunction

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_addr      = '0;
        in_data      = '0;
        in_wstrb     = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        load_addr    = 32'hFFFF_FFF0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit ret, iss, psh;
        sq_entry_t e;
        @(posedge clk);
        if (!resetn) begin
            q_pend.delete();
            q_out.delete();
        end else begin
            ret = data_data_ok && (q_out.size() != 0);
            iss = data_addr_ok && (q_pend.size() != 0);
            psh = in_valid && ((q_pend.size() + q_out.size()) < DEPTH);
            if (ret) void'(q_out.pop_front());
            if (iss) q_out.push_back(q_pend.pop_front());
            if (psh) begin
                e = '{addr: in_addr, data: in_data, wstrb: in_wstrb};
                q_pend.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        #1;
        n_tests++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", data_req); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_tests++; if (load_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got %b want 0", load_conflict); end
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; in_addr = 32'h1000_0003; in_wstrb = 4'b1000; in_data = 32'hAB00_0000;
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL single_req got %b want 1", data_req); end
        n_tests++; if (data_size !== 2'd0) begin n_fail++; $display("FAIL single_size got %0d want 0", data_size); end
        n_tests++; if (data_addr !== 32'h1000_0003) begin n_fail++; $display("FAIL single_addr got %h want 10000003", data_addr); end
        n_tests++; if (data_wdata !== 32'hAB00_0000) begin n_fail++; $display("FAIL single_wdata got %h want ab000000", data_wdata); end
        n_tests++; if (data_wr !== 1'b1) begin n_fail++; $display("FAIL single_wr got %b want 1", data_wr); end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        n_tests++; if (data_req !== 1'b0 || empty !== 1'b0) begin
            n_fail++; $display("FAIL single_issued req=%b empty=%b want req=0 empty=0", data_req, empty);
        end
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got %b want 1", empty); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_addr = 32'h5000_0000 + 32'(4 * i); in_wstrb = 4'hF;
            in_data  = 32'(i + 1);
            #1;
            n_tests++;
            if (in_ready !== (i < 4)) begin
                n_fail++; $display("FAIL full_ready_%0d got %b want %b", i, in_ready, i < 4);
            end
            tick();
        end
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_held got %b want 0", in_ready); end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass got %b want 0", in_ready); end
        tick();
        data_data_ok = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        data_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (data_wdata !== 32'(k + 2)) begin
                n_fail++; $display("FAIL full_order_%0d got %h want %h", k, data_wdata, 32'(k + 2));
            end
            tick();
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        repeat (4) tick();
        data_data_ok = 1'b0;
        #1;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drain got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_wstrb = 4'hF; in_addr = 32'h6000_0000; in_data = 32'hA;
        tick();
        in_addr = 32'h6000_0004; in_data = 32'hB; data_addr_ok = 1'b1;
        tick();
        in_addr = 32'h6000_0008; in_data = 32'hC; data_data_ok = 1'b1;
        #1;
        n_tests++; if (data_wdata !== 32'hB) begin n_fail++; $display("FAIL b2b_pre got %h want b", data_wdata); end
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        in_addr = 32'h6000_000C; in_data = 32'hD;
        #1;
        n_tests++; if (data_wdata !== 32'hC || data_req !== 1'b1) begin
            n_fail++; $display("FAIL b2b_post wdata=%h req=%b want c 1", data_wdata, data_req);
        end
        tick();
        in_addr = 32'h6000_0010; in_data = 32'hE;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_count3 got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_count4 got %b want 0", in_ready); end
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (data_wdata !== 32'hC + 32'(k)) begin
                n_fail++; $display("FAIL b2b_order_%0d got %h want %h", k, data_wdata, 32'hC + 32'(k));
            end
            tick();
        end
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_drain got %b want 1", empty); end
    endtask

    task automatic test_swl();
        in_valid = 1'b1; in_addr = 32'h2000_0002; in_wstrb = 4'b0111; in_data = 32'h0011_2233;
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++; if (data_size !== 2'd2) begin n_fail++; $display("FAIL swl_size got %0d want 2", data_size); end
        n_tests++; if (data_addr !== 32'h2000_0000) begin n_fail++; $display("FAIL swl_addr got %h want 20000000", data_addr); end
        n_tests++; if (data_wstrb !== 4'b0111) begin n_fail++; $display("FAIL swl_wstrb got %b want 0111", data_wstrb); end
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
    endtask

    task automatic test_load_conflict();
        logic want;
        in_valid = 1'b1; in_addr = 32'h3000_0004; in_wstrb = 4'hF; in_data = 32'h1234_5678;
        tick();
        in_valid = 1'b0;
        load_addr = 32'h3000_0006;
        #1;
        n_tests++; if (load_conflict !== 1'b1) begin n_fail++; $display("FAIL ld_same_word got %b want 1", load_conflict); end
        load_addr = 32'h3000_0008;
        #1;
`ifdef STORE_QUEUE_LOAD_CHECK_EN
        want = 1'b0;
`else
        want = 1'b1;
`endif
        n_tests++; if (load_conflict !== want) begin n_fail++; $display("FAIL ld_other_word got %b want %b", load_conflict, want); end
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        load_addr = 32'h3000_0005;
        #1;
        n_tests++; if (load_conflict !== 1'b1) begin n_fail++; $display("FAIL ld_outstanding got %b want 1", load_conflict); end
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        #1;
        n_tests++; if (load_conflict !== 1'b0) begin n_fail++; $display("FAIL ld_drained got %b want 0", load_conflict); end
        load_addr = 32'hFFFF_FFF0;
    endtask

    task automatic test_reset_midflight();
        in_valid = 1'b1; in_wstrb = 4'hF;
        in_addr = 32'h7000_0000; in_data = 32'h70; tick();
        in_addr = 32'h7000_0004; in_data = 32'h71; data_addr_ok = 1'b1; tick();
        in_addr = 32'h7000_0008; in_data = 32'h72; data_addr_ok = 1'b0; tick();
        in_valid = 1'b0;
        #1;
        n_tests++; if (data_req !== 1'b1 || empty !== 1'b0) begin
            n_fail++; $display("FAIL mid_setup req=%b empty=%b want 1 0", data_req, empty);
        end
        resetn = 1'b0;
        #1;
        n_tests++; if (data_req !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_async req=%b empty=%b ready=%b want 0 1 1", data_req, empty, in_ready);
        end
        tick();
        resetn = 1'b1;
        tick();
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        #1;
        n_tests++; if (empty !== 1'b1 || data_req !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_stray empty=%b req=%b ready=%b want 1 0 1", empty, data_req, in_ready);
        end
        in_valid = 1'b1; in_addr = 32'h7100_0001; in_wstrb = 4'b0010; in_data = 32'h0000_5500;
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++; if (data_req !== 1'b1 || data_addr !== 32'h7100_0001 || data_wdata !== 32'h0000_5500) begin
            n_fail++; $display("FAIL mid_restart req=%b addr=%h wdata=%h want 1 71000001 00005500",
                               data_req, data_addr, data_wdata);
        end
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] strbs [9];
        logic [1:0] ws;
        strbs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0111, 4'b1110};
        for (int c = 0; c < 400; c++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_addr      = 32'h4000_0000 | 32'($urandom_range(0, 15));
            in_data      = $urandom;
            in_wstrb     = strbs[$urandom_range(0, 8)];
            data_addr_ok = ($urandom_range(0, 2) == 0);
            data_data_ok = ($urandom_range(0, 2) == 0);
            load_addr    = 32'h4000_0000 | 32'($urandom_range(0, 15));
            #1;
            n_tests++;
            if (in_ready !== ((q_pend.size() + q_out.size()) < DEPTH)) begin
                n_fail++; $display("FAIL rnd_ready c=%0d got %b", c, in_ready);
            end
            n_tests++;
            if (empty !== ((q_pend.size() + q_out.size()) == 0)) begin
                n_fail++; $display("FAIL rnd_empty c=%0d got %b", c, empty);
            end
            n_tests++;
            if (data_req !== (q_pend.size() != 0)) begin
                n_fail++; $display("FAIL rnd_req c=%0d got %b want %b", c, data_req, q_pend.size() != 0);
            end
            n_tests++;
            if (load_conflict !== exp_conflict(load_addr)) begin
                n_fail++; $display("FAIL rnd_conflict c=%0d got %b want %b", c, load_conflict,
                                   exp_conflict(load_addr));
            end
            if (q_pend.size() != 0) begin
                ws = exp_size(q_pend[0].wstrb);
                n_tests++;
                if (data_addr !== exp_addr(q_pend[0]) || data_wdata !== q_pend[0].data ||
                    data_wstrb !== q_pend[0].wstrb || data_size !== ws) begin
                    n_fail++;
                    $display("FAIL rnd_req_fields c=%0d got %h/%h/%b/%0d want %h/%h/%b/%0d", c,
                             data_addr, data_wdata, data_wstrb, data_size, exp_addr(q_pend[0]),
                             q_pend[0].data, q_pend[0].wstrb, ws);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_back_to_back();
        test_swl();
        test_load_conflict();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
